// File: rtl/getir.sv
// rtl/getir.sv - instruction fetch stage with credit-limited outstanding reads
//
// getir_fifo: small synchronous FIFO used for the address and response queues.
//   clk_i      clock
//   rst_i      synchronous active-low reset
//   temizle    drop all entries (wins over yaz/oku)
//   yaz        push yaz_veri
//   oku        pop the head entry
//   bas_veri   current head entry (valid when sayi != 0)
//   sayi       number of stored entries
//
// getir: fetch stage. Keeps the program counter, issues word reads to the
// L1 instruction cache, pairs each returned word with its fetch address and
// presents it to decode through a registered output stage.
//   clk_i / rst_i                  clock, synchronous active-low reset
//   l1b_istek_o / l1b_adres_o      read request and word-aligned address
//   l1b_hazir_i                    cache accepts the request this cycle
//   l1b_gecerli_i / l1b_buyruk_i   in-order response and its instruction word
//   yurut_atlama_i / _adres_i      redirect from execute and its target
//   ddb_kontrol_durdur_i           hold the output register
//   ddb_kontrol_bosalt_i           flush the output register
//   buyruk_o, program_sayaci_o,
//   program_sayaci_artmis_o,
//   buyruk_gecerli_o               registered instruction, its pc, pc + 4, valid

module getir_fifo #(
  parameter int GENISLIK = 32,
  parameter int DERINLIK = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           temizle,
  input  logic                           yaz,
  input  logic [GENISLIK-1:0]            yaz_veri,
  input  logic                           oku,
  output logic [GENISLIK-1:0]            bas_veri,
  output logic [$clog2(DERINLIK+1)-1:0]  sayi
);

  localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int CW = $clog2(DERINLIK + 1);

  logic [GENISLIK-1:0] bellek [DERINLIK];
  logic [PW-1:0]       yaz_ptr;
  logic [PW-1:0]       oku_ptr;

  function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
    return (p == PW'(DERINLIK - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i || temizle) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz) begin
        bellek[yaz_ptr] <= yaz_veri;
        yaz_ptr         <= sonraki(yaz_ptr);
      end
      if (oku) begin
        oku_ptr <= sonraki(oku_ptr);
      end
      sayi <= sayi + CW'(yaz) - CW'(oku);
    end
  end

  assign bas_veri = bellek[oku_ptr];

endmodule

module getir #(
  parameter logic [31:0] RESET_PC       = 32'h4000_0000,
  parameter int          ISTEK_DERINLIK = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        l1b_istek_o,
  output logic [31:0] l1b_adres_o,
  input  logic        l1b_hazir_i,
  input  logic        l1b_gecerli_i,
  input  logic [31:0] l1b_buyruk_i,
  input  logic        yurut_atlama_i,
  input  logic [31:0] yurut_atlama_adres_i,
  input  logic        ddb_kontrol_durdur_i,
  input  logic        ddb_kontrol_bosalt_i,
  output logic [31:0] buyruk_o,
  output logic [31:0] program_sayaci_o,
  output logic [31:0] program_sayaci_artmis_o,
  output logic        buyruk_gecerli_o
);

  localparam int          CW  = $clog2(ISTEK_DERINLIK + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_r;
  logic [CW-1:0] at_sayac;

  logic [CW-1:0] adr_sayi;
  logic [31:0]   adr_bas;
  logic [CW-1:0] yanit_sayi;
  logic [63:0]   yanit_bas;

  logic          kabul;
  logic          yanit_geldi;
  logic          yanit_kullan;
  logic          ilerle;
  logic          yanit_yaz;
  logic          yanit_oku;
  logic [CW:0]   toplam;

  // The low target bits are forced to zero, so they are intentionally ignored.
  logic          unused_adres_bitleri;
  assign unused_adres_bitleri = ^yurut_atlama_adres_i[1:0];

  // Credit covers both in-flight reads and buffered words, so every response
  // that comes back always has a free response-FIFO slot.
  assign toplam      = {1'b0, adr_sayi} + {1'b0, yanit_sayi};
  assign l1b_istek_o = rst_i && !yurut_atlama_i && (toplam < (CW+1)'(ISTEK_DERINLIK));
  assign l1b_adres_o = pc_r;
  assign kabul       = l1b_istek_o && l1b_hazir_i;

  // A response only counts when something is actually in flight.
  assign yanit_geldi  = l1b_gecerli_i && (adr_sayi != '0);
  // Stale responses and those landing in a redirect cycle are dropped.
  assign yanit_kullan = yanit_geldi && (at_sayac == '0) && !yurut_atlama_i;

  assign ilerle    = !yurut_atlama_i && !ddb_kontrol_bosalt_i && !ddb_kontrol_durdur_i;
  assign yanit_oku = ilerle && (yanit_sayi != '0);
  // With an empty response FIFO and a free output stage the word bypasses the
  // FIFO straight into the output register; that keeps one instruction per cycle.
  assign yanit_yaz = yanit_kullan && !(ilerle && (yanit_sayi == '0));

  getir_fifo #(.GENISLIK(32), .DERINLIK(ISTEK_DERINLIK)) u_adr_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .temizle  (1'b0),
    .yaz      (kabul),
    .yaz_veri (pc_r),
    .oku      (yanit_geldi),
    .bas_veri (adr_bas),
    .sayi     (adr_sayi)
  );

  getir_fifo #(.GENISLIK(64), .DERINLIK(ISTEK_DERINLIK)) u_yanit_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .temizle  (yurut_atlama_i),
    .yaz      (yanit_yaz),
    .yaz_veri ({adr_bas, l1b_buyruk_i}),
    .oku      (yanit_oku),
    .bas_veri (yanit_bas),
    .sayi     (yanit_sayi)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_r <= RESET_PC;
    end else if (yurut_atlama_i) begin
      pc_r <= {yurut_atlama_adres_i[31:2], 2'b00};
    end else if (kabul) begin
      pc_r <= pc_r + 32'd4;
    end
  end

  // On redirect every read still in flight (after this cycle's pop) is stale.
  // The address FIFO holds exactly those reads, so its count is the new total.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      at_sayac <= '0;
    end else if (yurut_atlama_i) begin
      at_sayac <= adr_sayi - CW'(yanit_geldi);
    end else if (yanit_geldi && (at_sayac != '0)) begin
      at_sayac <= at_sayac - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      buyruk_o                <= NOP;
      program_sayaci_o        <= '0;
      program_sayaci_artmis_o <= '0;
      buyruk_gecerli_o        <= 1'b0;
    end else if (yurut_atlama_i || ddb_kontrol_bosalt_i) begin
      buyruk_o         <= NOP;
      buyruk_gecerli_o <= 1'b0;
    end else if (ddb_kontrol_durdur_i) begin
      buyruk_o                <= buyruk_o;
      program_sayaci_o        <= program_sayaci_o;
      program_sayaci_artmis_o <= program_sayaci_artmis_o;
      buyruk_gecerli_o        <= buyruk_gecerli_o;
    end else if (yanit_sayi != '0) begin
      buyruk_o                <= yanit_bas[31:0];
      program_sayaci_o        <= yanit_bas[63:32];
      program_sayaci_artmis_o <= yanit_bas[63:32] + 32'd4;
      buyruk_gecerli_o        <= 1'b1;
    end else if (yanit_kullan) begin
      buyruk_o                <= l1b_buyruk_i;
      program_sayaci_o        <= adr_bas;
      program_sayaci_artmis_o <= adr_bas + 32'd4;
      buyruk_gecerli_o        <= 1'b1;
    end else begin
      buyruk_o         <= NOP;
      buyruk_gecerli_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_getir.sv
// tb/tb_getir.sv - randomized self-checking bench for the getir fetch stage

module tb_getir;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        l1b_istek_o;
  logic [31:0] l1b_adres_o;
  logic        l1b_hazir_i;
  logic        l1b_gecerli_i;
  logic [31:0] l1b_buyruk_i;
  logic        yurut_atlama_i;
  logic [31:0] yurut_atlama_adres_i;
  logic        ddb_kontrol_durdur_i;
  logic        ddb_kontrol_bosalt_i;
  logic [31:0] buyruk_o;
  logic [31:0] program_sayaci_o;
  logic [31:0] program_sayaci_artmis_o;
  logic        buyruk_gecerli_o;

  getir dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .l1b_istek_o             (l1b_istek_o),
    .l1b_adres_o             (l1b_adres_o),
    .l1b_hazir_i             (l1b_hazir_i),
    .l1b_gecerli_i           (l1b_gecerli_i),
    .l1b_buyruk_i            (l1b_buyruk_i),
    .yurut_atlama_i          (yurut_atlama_i),
    .yurut_atlama_adres_i    (yurut_atlama_adres_i),
    .ddb_kontrol_durdur_i    (ddb_kontrol_durdur_i),
    .ddb_kontrol_bosalt_i    (ddb_kontrol_bosalt_i),
    .buyruk_o                (buyruk_o),
    .program_sayaci_o        (program_sayaci_o),
    .program_sayaci_artmis_o (program_sayaci_artmis_o),
    .buyruk_gecerli_o        (buyruk_gecerli_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cache contents: every address holds a word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } req_t;

  // Reference model: program order since the last redirect, plus the cache.
  req_t        q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_exp_pc;
  int          m_epoch;
  int          m_buf;
  int          cyc;
  bit          saw_wrap;

  // Stimulus knobs.
  logic        k_hazir, k_atlama, k_bosalt, k_durdur;
  logic [31:0] k_target;
  int          k_lat_max, k_rsp_pct;

  task automatic step();
    logic        resp_now, good, avail, accept;
    logic [31:0] p_buyruk, p_pc, p_art, e_art;
    logic        p_gec;
    @(negedge clk_i);
    l1b_hazir_i          = k_hazir;
    yurut_atlama_i       = k_atlama;
    yurut_atlama_adres_i = k_target;
    ddb_kontrol_bosalt_i = k_bosalt;
    ddb_kontrol_durdur_i = k_durdur;
    resp_now = 1'b0;
    if (q.size() > 0 && cyc >= q[0].ready && $urandom_range(99) < k_rsp_pct) begin
      resp_now = 1'b1;
    end
    l1b_gecerli_i = resp_now;
    l1b_buyruk_i  = resp_now ? mem_word(q[0].addr) : $urandom;
    #1;
    chk("istek", l1b_istek_o, !k_atlama && (q.size() + m_buf < 2));
    if (l1b_istek_o) chk("adres", l1b_adres_o, m_fetch_pc);
    p_buyruk = buyruk_o;
    p_pc     = program_sayaci_o;
    p_art    = program_sayaci_artmis_o;
    p_gec    = buyruk_gecerli_o;
    accept   = l1b_istek_o && k_hazir;
    good     = resp_now && (q[0].epoch == m_epoch) && !k_atlama;
    avail    = (m_buf > 0) || good;
    @(posedge clk_i);
    #1;
    if (resp_now) void'(q.pop_front());
    if (accept) begin
      q.push_back('{addr: m_fetch_pc, epoch: m_epoch,
                    ready: cyc + 1 + $urandom_range(k_lat_max)});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (k_atlama) begin
      m_epoch++;
      m_fetch_pc = {k_target[31:2], 2'b00};
      m_exp_pc   = m_fetch_pc;
      m_buf      = 0;
      chk("redirect_gecerli", buyruk_gecerli_o, 1'b0);
      chk("redirect_nop", buyruk_o, NOP);
    end else if (k_bosalt) begin
      if (good) m_buf++;
      chk("bosalt_gecerli", buyruk_gecerli_o, 1'b0);
      chk("bosalt_nop", buyruk_o, NOP);
    end else if (k_durdur) begin
      if (good) m_buf++;
      chk("durdur_hold", {buyruk_o, program_sayaci_o}, {p_buyruk, p_pc});
      chk("durdur_hold2", {program_sayaci_artmis_o, 31'd0, buyruk_gecerli_o},
          {p_art, 31'd0, p_gec});
    end else if (avail) begin
      e_art = m_exp_pc + 32'd4;
      chk("out_gecerli", buyruk_gecerli_o, 1'b1);
      chk("out_pc", program_sayaci_o, m_exp_pc);
      chk("out_artmis", program_sayaci_artmis_o, e_art);
      chk("out_buyruk", buyruk_o, mem_word(m_exp_pc));
      if (m_exp_pc == 32'hFFFF_FFFC && program_sayaci_artmis_o == 32'h0) saw_wrap = 1'b1;
      m_exp_pc = e_art;
      m_buf    = m_buf + (good ? 1 : 0) - 1;
    end else begin
      chk("idle_gecerli", buyruk_gecerli_o, 1'b0);
      chk("idle_nop", buyruk_o, NOP);
    end
    cyc++;
  endtask

  task automatic knobs(input logic h, input logic a, input logic [31:0] t,
                       input logic b, input logic d, input int lat, input int pct);
    k_hazir = h; k_atlama = a; k_target = t; k_bosalt = b; k_durdur = d;
    k_lat_max = lat; k_rsp_pct = pct;
  endtask

  initial begin
    logic [31:0] saved;
    rst_i = 1'b0;
    l1b_hazir_i = 1'b0; l1b_gecerli_i = 1'b0; l1b_buyruk_i = '0;
    yurut_atlama_i = 1'b0; yurut_atlama_adres_i = '0;
    ddb_kontrol_durdur_i = 1'b0; ddb_kontrol_bosalt_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_istek", l1b_istek_o, 1'b0);
    chk("rst_buyruk", buyruk_o, NOP);
    chk("rst_pc", program_sayaci_o, 32'h0);
    chk("rst_artmis", program_sayaci_artmis_o, 32'h0);
    chk("rst_gecerli", buyruk_gecerli_o, 1'b0);
    chk("rst_adres", l1b_adres_o, 32'h4000_0000);
    rst_i = 1'b1;
    m_fetch_pc = 32'h4000_0000; m_exp_pc = 32'h4000_0000;
    m_epoch = 0; m_buf = 0; cyc = 0; saw_wrap = 1'b0;

    // 1: streaming with single-cycle cache responses.
    knobs(1, 0, 0, 0, 0, 0, 100);
    step();
    chk("t1_not_yet", buyruk_gecerli_o, 1'b0);
    step();
    chk("t1_first_valid", buyruk_gecerli_o, 1'b1);
    chk("t1_first_pc", program_sayaci_o, 32'h4000_0000);
    chk("t1_first_art", program_sayaci_artmis_o, 32'h4000_0004);
    repeat (6) step();

    // 2: cache not ready; request and address must stay put.
    knobs(0, 0, 0, 0, 0, 0, 100);
    step();
    saved = l1b_adres_o;
    repeat (5) step();
    chk("t2_adres_stable", l1b_adres_o, saved);
    chk("t2_istek_high", l1b_istek_o, 1'b1);

    // 3: redirect with two reads in flight.
    knobs(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("t3_inflight", q.size(), 2);
    knobs(0, 1, 32'h4000_0103, 0, 0, 0, 100);
    step();
    chk("t3_target", l1b_adres_o, 32'h4000_0100);
    knobs(1, 0, 0, 0, 0, 0, 100);
    repeat (8) step();

    // 4: stall while responses keep arriving.
    knobs(1, 0, 0, 0, 1, 0, 100);
    repeat (3) step();
    chk("t4_credit_full", l1b_istek_o, 1'b0);
    knobs(1, 0, 0, 0, 0, 0, 100);
    repeat (4) step();

    // 5: flush and stall together with a buffered instruction.
    knobs(1, 0, 0, 0, 1, 0, 100);
    repeat (2) step();
    knobs(0, 0, 0, 1, 1, 0, 100);
    step();
    chk("t5_flush", buyruk_gecerli_o, 1'b0);
    knobs(0, 0, 0, 0, 0, 0, 100);
    step();
    chk("t5_next", buyruk_gecerli_o, 1'b1);
    repeat (4) step();

    // 6: redirect to the top of the address space.
    knobs(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 100);
    step();
    chk("t6_adres", l1b_adres_o, 32'hFFFF_FFFC);
    knobs(1, 0, 0, 0, 0, 0, 100);
    step();
    chk("t6_wrap_adres", l1b_adres_o, 32'h0000_0000);
    repeat (5) step();
    chk("t6_wrap_artmis", saw_wrap, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      knobs($urandom_range(99) < 70, $urandom_range(99) < 4, $urandom,
            $urandom_range(99) < 5, $urandom_range(99) < 15, 3, 70);
      step();
    end

    // Drain: everything fetched since the last redirect must have come out.
    knobs(0, 0, 0, 0, 0, 0, 100);
    repeat (20) step();
    chk("drain_inflight", q.size(), 0);
    chk("drain_order", m_exp_pc, m_fetch_pc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
